// File: rtl/hb_state_ctrl_if.sv
// Plaintext-in / ciphertext-out handshake bundle for hb_state_ctrl.
// The master side supplies words and drains results; the slave side is the controller.
interface hb_state_ctrl_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/hb_state_ctrl.sv
// State controller for the four-round encryption datapath.
// It owns RS1-RS4 and the LFSR, runs IV initialisation, and moves one plaintext
// word per two cycles through the external combinational datapath.
module hb_state_ctrl #(
  parameter int unsigned INIT_ROUNDS = 4,
  parameter logic [15:0] LFSR_FORCE  = 16'h1000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [63:0]           iv,
  hb_state_ctrl_if.slave        bus,
  output logic                  init_done,
  output logic [15:0]           enc_datain,
  output logic [15:0]           rs1,
  output logic [15:0]           rs2,
  output logic [15:0]           rs3,
  output logic [15:0]           rs4,
  input  logic [15:0]           enc1_out,
  input  logic [15:0]           enc2_out,
  input  logic [15:0]           enc3_out,
  input  logic [15:0]           enc_dataout
);

  // Counter is wide enough to hold INIT_ROUNDS itself, so cnt++ on the last
  // iteration never wraps back to a value that looks like an early iteration.
  localparam int unsigned      CNT_W    = $clog2(INIT_ROUNDS + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(INIT_ROUNDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INIT = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic               pend;
  logic [15:0]        pt_reg;
  logic [15:0]        lfsr;
  logic               out_valid_r;
  logic [15:0]        out_data_r;

  logic               init_step;
  logic               last_iter;
  logic               compute;
  logic               accept;
  logic               in_ready_c;
  logic [15:0]        lfsr_nxt;
  logic [15:0]        rs1_blk;

  // Modulo-2^16 addition; the carry out is intentionally dropped.
  function automatic logic [15:0] add16(input logic [15:0] a, input logic [15:0] b);
    return 16'(a + b);
  endfunction

  // One step of the 16-bit Fibonacci LFSR (taps 15,14,11,9,6,2).
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[14] ^ s[11] ^ s[9] ^ s[6] ^ s[2]};
  endfunction

  assign lfsr_nxt      = lfsr_step(lfsr);
  assign rs1_blk       = add16(rs1, enc1_out);
  assign init_done     = (state == RUN);
  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = out_data_r;

  // Next-state decode plus per-cycle strobes and the datapath input select.
  always_comb begin
    state_nxt  = state;
    init_step  = 1'b0;
    last_iter  = 1'b0;
    compute    = 1'b0;
    accept     = 1'b0;
    in_ready_c = 1'b0;
    enc_datain = pt_reg;
    case (state)
      IDLE: state_nxt = IDLE;
      INIT: begin
        enc_datain = add16(rs1, rs3);
        init_step  = 1'b1;
        last_iter  = (cnt == LAST_CNT);
        if (last_iter) state_nxt = RUN;
      end
      RUN: begin
        // A word may only enter when the result slot will be free on this edge.
        in_ready_c = !pend && (!out_valid_r || bus.out_ready);
        accept     = bus.in_valid && in_ready_c;
        compute    = pend;
      end
      default: state_nxt = IDLE;
    endcase
    // start aborts whatever is in flight and restarts initialisation.
    if (start) state_nxt = INIT;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // State registers, LFSR, plaintext capture and result slot.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rs1         <= '0;
      rs2         <= '0;
      rs3         <= '0;
      rs4         <= '0;
      lfsr        <= '0;
      cnt         <= '0;
      pend        <= 1'b0;
      pt_reg      <= '0;
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
    end else if (start) begin
      rs1         <= iv[15:0];
      rs2         <= iv[31:16];
      rs3         <= iv[47:32];
      rs4         <= iv[63:48];
      cnt         <= '0;
      pend        <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      if (init_step) begin
        rs1 <= add16(rs1, enc3_out);
        rs2 <= add16(rs2, enc1_out);
        rs3 <= add16(rs3, enc2_out);
        rs4 <= add16(rs4, enc_dataout);
        cnt <= cnt + CNT_W'(1);
        if (last_iter) lfsr <= enc_dataout | LFSR_FORCE;
      end
      if (accept) begin
        pt_reg <= bus.in_data;
        pend   <= 1'b1;
      end
      if (compute) begin
        out_data_r  <= enc_dataout;
        out_valid_r <= 1'b1;
        pend        <= 1'b0;
        rs1         <= rs1_blk;
        lfsr        <= lfsr_nxt;
        rs2         <= add16(add16(rs2, enc2_out), lfsr_nxt);
        rs3         <= add16(add16(rs3, enc3_out), rs1_blk);
        rs4         <= add16(add16(rs4, enc_dataout), rs1_blk);
      end else if (out_valid_r && bus.out_ready) begin
        out_valid_r <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_hb_state_ctrl.sv
// Scoreboard bench for hb_state_ctrl: directed scenarios on a constant datapath
// stub, then randomized traffic on a data-dependent toy datapath.
`timescale 1ns/1ps
module tb_hb_state_ctrl;

  localparam int          ROUNDS = 4;
  localparam logic [63:0] IV0    = 64'h0004_0003_0002_0001;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start;
  logic [63:0] iv;
  logic        init_done;
  logic [15:0] enc_datain;
  logic [15:0] rs1, rs2, rs3, rs4;
  logic [15:0] enc1_out, enc2_out, enc3_out, enc_dataout;

  hb_state_ctrl_if bus();

  hb_state_ctrl #(.INIT_ROUNDS(ROUNDS), .LFSR_FORCE(16'h1000)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .iv          (iv),
    .bus         (bus),
    .init_done   (init_done),
    .enc_datain  (enc_datain),
    .rs1         (rs1),
    .rs2         (rs2),
    .rs3         (rs3),
    .rs4         (rs4),
    .enc1_out    (enc1_out),
    .enc2_out    (enc2_out),
    .enc3_out    (enc3_out),
    .enc_dataout (enc_dataout)
  );

  // Datapath stand-in: constants, or a toy mixing function of state and input.
  logic        cmode;
  logic [15:0] c1, c2, c3, c4;

  function automatic logic [63:0] dp(input logic [15:0] a1, a2, a3, a4, d);
    logic [15:0] e1, e2, e3, e4;
    if (cmode) return {c4, c3, c2, c1};
    e1 = (a1 ^ d) + 16'h3a5c;
    e2 = {e1[10:0], e1[15:11]} ^ a2;
    e3 = e2 + a3 + 16'h0101;
    e4 = {e3[6:0], e3[15:7]} ^ a4 ^ d;
    return {e4, e3, e2, e1};
  endfunction

  always_comb {enc_dataout, enc3_out, enc2_out, enc1_out} = dp(rs1, rs2, rs3, rs4, enc_datain);

  // Transaction-level reference model.
  typedef struct {
    logic [15:0] ct;
    logic [63:0] st;   // {rs4, rs3, rs2, rs1} after the block
  } exp_t;

  exp_t        q[$];
  logic [15:0] m_rs[4];
  logic [15:0] m_lfsr;
  int          checks = 0;
  int          errors = 0;
  int          acc_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  function automatic logic [15:0] lfsr_adv(input logic [15:0] s);
    return {s[14:0], ^(s & 16'hCA44)};
  endfunction

  task automatic model_start(input logic [63:0] v);
    logic [63:0] e;
    for (int k = 0; k < 4; k++) m_rs[k] = v[16*k +: 16];
    for (int i = 0; i < ROUNDS; i++) begin
      e = dp(m_rs[0], m_rs[1], m_rs[2], m_rs[3], m_rs[0] + m_rs[2]);
      m_rs[0] = m_rs[0] + e[47:32];
      m_rs[1] = m_rs[1] + e[15:0];
      m_rs[2] = m_rs[2] + e[31:16];
      m_rs[3] = m_rs[3] + e[63:48];
      if (i == ROUNDS - 1) m_lfsr = e[63:48] | 16'h1000;
    end
  endtask

  task automatic model_block(input logic [15:0] pt);
    logic [63:0] e;
    logic [15:0] r1;
    exp_t        x;
    e       = dp(m_rs[0], m_rs[1], m_rs[2], m_rs[3], pt);
    r1      = m_rs[0] + e[15:0];
    m_lfsr  = lfsr_adv(m_lfsr);
    m_rs[1] = m_rs[1] + e[31:16] + m_lfsr;
    m_rs[2] = m_rs[2] + e[47:32] + r1;
    m_rs[3] = m_rs[3] + e[63:48] + r1;
    m_rs[0] = r1;
    x.ct    = e[63:48];
    x.st    = {m_rs[3], m_rs[2], m_rs[1], m_rs[0]};
    q.push_back(x);
  endtask

  // Stimulus side of the scoreboard: every accepted word yields one expectation.
  always @(negedge clk) begin
    if (rst_n && !start && bus.in_valid && bus.in_ready) begin
      model_block(bus.in_data);
      acc_cnt++;
    end
  end

  // Monitor: each output handshake consumes the oldest expectation.
  always @(negedge clk) begin
    exp_t x;
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_underflow: got output %h, expected no output", bus.out_data);
      end else begin
        x = q.pop_front();
        chk("sb_data", {48'h0, bus.out_data}, {48'h0, x.ct});
        chk("sb_state", {rs4, rs3, rs2, rs1}, x.st);
      end
    end
  end

  task automatic do_start(input logic [63:0] v);
    @(posedge clk); #1;
    start         = 1'b1;
    iv            = v;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    q.delete();
    model_start(v);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  initial begin
    int last;
    int base;
    rst_n         = 1'b0;
    start         = 1'b0;
    iv            = '0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 16'h1111;
    bus.out_ready = 1'b1;
    cmode         = 1'b1;
    c1 = 16'h0010; c2 = 16'h0020; c3 = 16'h0030; c4 = 16'h0040;
    m_lfsr = '0;
    for (int k = 0; k < 4; k++) m_rs[k] = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state: nothing moves without start, even with in_valid high.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_ctrl", {61'h0, bus.out_valid, bus.in_ready, init_done}, 64'h0);
      chk("rst_data", {32'h0, bus.out_data, enc_datain}, 64'h0);
      chk("rst_rs", {rs4, rs3, rs2, rs1}, 64'h0);
    end

    // Initialisation.
    do_start(IV0);
    chk("init_load", {rs4, rs3, rs2, rs1}, IV0);
    chk("init_din0", {48'h0, enc_datain}, 64'h0004);
    chk("init_busy", {63'h0, init_done}, 64'h0);
    @(posedge clk); #1;
    chk("init_din1", {48'h0, enc_datain}, 64'h0054);
    repeat (3) @(posedge clk); #1;
    chk("init_done", {63'h0, init_done}, 64'h1);
    chk("init_rs", {rs4, rs3, rs2, rs1}, 64'h0104_0083_0042_00C1);

    // First block, held under backpressure.
    bus.in_valid  = 1'b1;
    bus.in_data   = 16'h1234;
    bus.out_ready = 1'b0;
    #1;
    chk("blk_ready", {63'h0, bus.in_ready}, 64'h1);
    @(posedge clk); #1;
    bus.in_data = 16'h5678;
    @(posedge clk); #1;
    chk("blk_valid", {63'h0, bus.out_valid}, 64'h1);
    chk("blk_data", {48'h0, bus.out_data}, 64'h0040);
    chk("blk_rs", {rs4, rs3, rs2, rs1}, 64'h0215_0184_20E3_00D1);
    repeat (5) begin
      @(posedge clk); #1;
      chk("bp_ready", {63'h0, bus.in_ready}, 64'h0);
      chk("bp_frozen", {rs4, rs3, rs2, rs1}, 64'h0215_0184_20E3_00D1);
      chk("bp_hold", {47'h0, bus.out_valid, bus.out_data}, 64'h1_0040);
    end
    base = acc_cnt;
    last = acc_cnt;
    bus.out_ready = 1'b1;
    repeat (8) begin
      @(posedge clk); #1;
      if (acc_cnt != last) begin
        bus.in_data = 16'($urandom);
        last = acc_cnt;
      end
    end
    chk("bp_rate", 64'(acc_cnt - base), 64'd4);
    bus.in_valid = 1'b0;
    repeat (4) @(posedge clk); #1;
    chk("bp_drain", 64'(q.size()), 64'd0);

    // Wrap-around of the modular add.
    c3 = 16'h0002;
    do_start(64'h0004_0003_0002_FFFF);
    chk("wrap_load", {48'h0, rs1}, 64'hFFFF);
    @(posedge clk); #1;
    chk("wrap_rs1", {48'h0, rs1}, 64'h0001);
    repeat (4) @(posedge clk); #1;
    c3 = 16'h0030;

    // Restart during a compute cycle.
    do_start(IV0);
    repeat (4) @(posedge clk); #1;
    bus.in_valid  = 1'b1;
    bus.in_data   = 16'hAAAA;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    start         = 1'b1;
    iv            = IV0;
    q.delete();
    model_start(IV0);
    @(posedge clk); #1;
    start = 1'b0;
    chk("rst_abort_valid", {63'h0, bus.out_valid}, 64'h0);
    chk("rst_reload", {rs4, rs3, rs2, rs1}, IV0);
    chk("rst_din0", {48'h0, enc_datain}, 64'h0004);
    @(posedge clk); #1;
    chk("rst_din1", {48'h0, enc_datain}, 64'h0054);
    chk("rst_abort_hold", {63'h0, bus.out_valid}, 64'h0);
    repeat (3) @(posedge clk); #1;
    chk("rst_init_rs", {rs4, rs3, rs2, rs1}, 64'h0104_0083_0042_00C1);
    chk("rst_init_done", {63'h0, init_done}, 64'h1);
    bus.in_valid  = 1'b1;
    bus.in_data   = 16'h1234;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    chk("rst_blk_rs2", {48'h0, rs2}, 64'h20E3);
    repeat (3) @(posedge clk); #1;

    // Randomized traffic on the toy datapath.
    cmode = 1'b0;
    for (int ep = 0; ep < 6; ep++) begin
      do_start({$urandom, $urandom});
      last = acc_cnt;
      for (int cyc = 0; cyc < 150; cyc++) begin
        @(posedge clk); #1;
        if (!bus.in_valid || acc_cnt != last) begin
          bus.in_valid = ($urandom_range(0, 3) != 0);
          bus.in_data  = 16'($urandom);
        end
        last = acc_cnt;
        bus.out_ready = ($urandom_range(0, 3) != 0);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      repeat (6) @(posedge clk); #1;
      chk("ep_drain", 64'(q.size()), 64'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hb_state_ctrl.md
# hb_state_ctrl

Sequential state controller wrapped around the combinational four-round encryption datapath. It owns the internal state registers RS1–RS4 and the 16-bit LFSR, and runs the IV initialisation sequence. It also accepts plaintext words over a valid/ready handshake, drives the datapath input, and captures the ciphertext. After each block it updates the state from the datapath's intermediate round outputs. The datapath is instantiated beside this block: its rs1..rs4 inputs come from this block, and its enc1/enc2/enc3/dataout outputs come back here.

## Interface
- INIT_ROUNDS, 4, number of initialisation iterations (≥1).
- LFSR_FORCE, 16'h1000, OR-mask applied when seeding the LFSR; guarantees a non-zero seed.
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  one-cycle pulse: load IV and begin initialisation (abort-and-restart from any state).
- iv  in  64  initial state: rs1=iv[15:0], rs2=iv[31:16], rs3=iv[47:32], rs4=iv[63:48].
- in_valid / in_ready  in / out  1 / 1  plaintext handshake.
- in_data  in  16  plaintext word.
- out_valid / out_ready  out / in  1 / 1  ciphertext handshake.
- out_data  out  16  ciphertext word.
- init_done  out  1  high while in RUN.
- enc_datain  out  16  datapath input.
- rs1, rs2, rs3, rs4  out  16 each  current state registers, fed to the datapath.
- enc1_out, enc2_out, enc3_out, enc_dataout  in  16 each  datapath round outputs (v12, v23, v34, ciphertext).

## Operation
- All additions (⊞) are modulo 2^16; carries are discarded.
- FSM states: IDLE, INIT, RUN.
  - IDLE → INIT on start.
  - INIT → RUN after INIT_ROUNDS iterations.
  - start in any state → INIT, with pend, out_valid and the round counter cleared.
- start cycle: RS1–RS4 are loaded from iv and cnt=0.
- INIT, one iteration per cycle:
  - enc_datain = rs1 ⊞ rs3.
  - On the clock edge: rs1+=enc3_out, rs2+=enc1_out, rs3+=enc2_out, rs4+=enc_dataout; cnt++.
  - On the last iteration also: lfsr = enc_dataout | LFSR_FORCE.
- LFSR step: lfsr' = {lfsr[14:0], lfsr[15]^lfsr[14]^lfsr[11]^lfsr[9]^lfsr[6]^lfsr[2]}.
- RUN accept:
  - in_ready = RUN && !pend && (!out_valid || out_ready).
  - On in_valid && in_ready: pt_reg=in_data, pend=1.
- RUN compute cycle (pend=1):
  - enc_datain = pt_reg.
  - On the clock edge:
    - out_data=enc_dataout, out_valid=1, pend=0.
    - rs1' = rs1 ⊞ enc1_out.
    - lfsr' = step(lfsr).
    - rs2' = rs2 ⊞ enc2_out ⊞ lfsr'.
    - rs3' = rs3 ⊞ enc3_out ⊞ rs1'.
    - rs4' = rs4 ⊞ enc_dataout ⊞ rs1'.
- Outside INIT and compute cycles: enc_datain = pt_reg.
- out_valid is held, and out_data stable, until out_ready is sampled high. They are cleared on that edge unless a new result is captured on the same edge.
- in_valid while not in RUN is ignored; in_ready stays 0.

## Timing
- Reset (rst_n=0 at an edge) forces:
  - state=IDLE, cnt=0, pend=0, pt_reg=0.
  - rs1..rs4=0, lfsr=0.
  - out_valid=0, out_data=0, in_ready=0, init_done=0, enc_datain=0.
- Reset overrides start.
- start sampled at edge N → INIT from N+1 → RUN and init_done=1 after INIT_ROUNDS further edges (edge N+4 by default).
- Latency: word accepted at edge M → out_valid=1 with its ciphertext after edge M+1.
- Throughput: 1 word per 2 cycles with out_ready tied high.
- Backpressure: with out_valid=1 and out_ready=0, in_ready=0 and no state update occurs. Ordering is strict; no word is lost or duplicated.
- start during a compute cycle discards the pending word and any unread output. No state update is made from the aborted word.

## Test plan
For all scenarios: iv = {0004,0003,0002,0001}, and the datapath is stubbed to constants enc1=0010, enc2=0020, enc3=0030, dataout=0040.
- **Reset state:** reset, then release with no start → all outputs 0 and in_ready=0 indefinitely.
- **Initialisation:** pulse start → enc_datain=0004 in iteration 0 and 0054 in iteration 1. After 4 iterations: rs1=00C1, rs2=0042, rs3=0083, rs4=0104, lfsr=1040, init_done=1.
- **First block:** continue from the initialisation scenario, send in_data=1234 → one cycle later out_data=0040, out_valid=1, rs1=00D1, lfsr=2081, rs2=20E3, rs3=0184, rs4=0215.
- **Backpressure:** hold out_ready=0 for 5 cycles while in_valid=1 → in_ready=0 and rs registers frozen. Release out_ready → exactly one further word is accepted per 2 cycles, in order.
- **Wrap-around:** iv rs1=FFFF with enc3=0002 → rs1=0001 after INIT iteration 0.
- **Restart mid-operation:** start asserted in the compute cycle → out_valid stays 0, rs1..rs4 are reloaded from iv, and the INIT sequence repeats identically.
